// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: turns the ID-stage comparator result into a PC redirect
// toward fetch. It stalls ID until the compare operands arrive and holds the
// redirect in a valid/ready handshake. Delay-slot semantics apply, so no flush
// is ever issued.
// Optional feature macro: BRU_STATS_EN adds the taken/not-taken branch counters.
// When the macro is undefined, both counter outputs are tied to zero.

module branch_resolve_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OFF_W  = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    input  logic              br_is_reg,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [OFF_W-1:0]  br_offset,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              operands_ok,
    input  logic              cmp_taken,
    output logic              id_stall,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc,
    input  logic              redir_ready,
    output logic [CNT_W-1:0]  stat_taken,
    output logic [CNT_W-1:0]  stat_ntaken
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic              taken;
    logic              resolve;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] cond_target;
    logic [ADDR_W-1:0] target;

    // Sign-extended word offset. The target wraps silently modulo 2^ADDR_W.
    assign off_ext     = ADDR_W'($signed(br_offset));
    assign cond_target = br_pc + ADDR_W'(4) + (off_ext << 2);
    assign target      = br_is_reg ? reg_target : cond_target;
    assign taken       = br_is_reg | cmp_taken;

    // A branch is consumed only when no redirect is pending and its operands are valid.
    assign resolve = (state != HOLD) && br_valid && operands_ok;

    // Stall ID while the branch cannot be consumed. Reset forces the stall low at once.
    always_comb begin
        id_stall = 1'b0;
        if (!reset) begin
            if (state == HOLD) begin
                id_stall = br_valid;
            end else begin
                id_stall = br_valid & ~operands_ok;
            end
        end
    end

    // Resolution FSM with the registered redirect handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
        end else begin
            case (state)
                IDLE, WAIT: begin
                    if (resolve) begin
                        if (taken) begin
                            redir_pc    <= target;
                            redir_valid <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (br_valid) begin
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    redir_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef BRU_STATS_EN
    // Count consumed branches by outcome. The counters wrap at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_taken  <= '0;
            stat_ntaken <= '0;
        end else if (resolve) begin
            if (taken) begin
                stat_taken <= stat_taken + CNT_W'(1);
            end else begin
                stat_ntaken <= stat_ntaken + CNT_W'(1);
            end
        end
    end
`else
    assign stat_taken  = '0;
    assign stat_ntaken = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit. It uses a queue-style reference
// model, checks every cycle, and adds literal spot checks.

module tb_branch_resolve_unit;

`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_is_reg = 1'b0;
    logic [31:0] br_pc = '0;
    logic [15:0] br_offset = '0;
    logic [31:0] reg_target = '0;
    logic        operands_ok = 1'b0;
    logic        cmp_taken = 1'b0;
    logic        redir_ready = 1'b0;
    logic        id_stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] stat_taken;
    logic [31:0] stat_ntaken;

    int n_chk = 0;
    int n_fail = 0;

    branch_resolve_unit dut (
        .clk         (clk),
        .reset       (reset),
        .br_valid    (br_valid),
        .br_is_reg   (br_is_reg),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .reg_target  (reg_target),
        .operands_ok (operands_ok),
        .cmp_taken   (cmp_taken),
        .id_stall    (id_stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_ready (redir_ready),
        .stat_taken  (stat_taken),
        .stat_ntaken (stat_ntaken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending redirect slot and two branch tallies.
    logic        m_pend = 1'b0;
    logic [31:0] m_pc = '0;
    int          m_t = 0;
    int          m_nt = 0;

    function automatic logic [31:0] model_target();
        longint t;
        if (br_is_reg) return reg_target;
        t = longint'(br_pc) + 64'sd4 + longint'($signed(br_offset)) * 64'sd4;
        return t[31:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = 1'b0;
            m_pc   = '0;
            m_t    = 0;
            m_nt   = 0;
        end else begin
            logic was_pend;
            was_pend = m_pend;
            if (was_pend && redir_ready) m_pend = 1'b0;
            if (!was_pend && br_valid && operands_ok) begin
                if (br_is_reg || cmp_taken) begin
                    m_pend = 1'b1;
                    m_pc   = model_target();
                    m_t++;
                end else begin
                    m_nt++;
                end
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic exp_stall;
        if (reset) exp_stall = 1'b0;
        else if (m_pend) exp_stall = br_valid;
        else exp_stall = br_valid & ~operands_ok;
        chk("cyc_id_stall", 32'(id_stall), 32'(exp_stall));
        chk("cyc_redir_valid", 32'(redir_valid), 32'(m_pend));
        if (m_pend) chk("cyc_redir_pc", redir_pc, m_pc);
        chk("cyc_stat_taken", stat_taken, STATS ? 32'(m_t) : 32'd0);
        chk("cyc_stat_ntaken", stat_ntaken, STATS ? 32'(m_nt) : 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic v, input logic isreg, input logic [31:0] pc,
                          input logic [15:0] off, input logic ok, input logic cmp);
        br_valid    = v;
        br_is_reg   = isreg;
        br_pc       = pc;
        br_offset   = off;
        operands_ok = ok;
        cmp_taken   = cmp;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_id_stall", 32'(id_stall), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: taken branch with a backward offset
        redir_ready = 1'b1;
        set_br(1'b1, 1'b0, 32'h0040_0010, 16'hFFFC, 1'b1, 1'b1);
        #1 chk("t1_stall", 32'(id_stall), 32'd0);
        tick();
        br_valid = 1'b0;
        #1;
        chk("t1_valid", 32'(redir_valid), 32'd1);
        chk("t1_pc", redir_pc, 32'h0040_0004);
        chk("t1_stall_after", 32'(id_stall), 32'd0);
        tick();
        chk("t1_valid_drop", 32'(redir_valid), 32'd0);

        // 2: not-taken branch
        set_br(1'b1, 1'b0, 32'h0040_0010, 16'hFFFC, 1'b1, 1'b0);
        #1 chk("t2_stall", 32'(id_stall), 32'd0);
        tick();
        br_valid = 1'b0;
        #1;
        chk("t2_valid", 32'(redir_valid), 32'd0);
        chk("t2_ntaken", stat_ntaken, STATS ? 32'd1 : 32'd0);
        tick();

        // 3: operand hazard for three cycles (comparator output is ignored meanwhile)
        set_br(1'b1, 1'b0, 32'h0000_1000, 16'h0010, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_stall_wait", 32'(id_stall), 32'd1);
            chk("t3_no_redir", 32'(redir_valid), 32'd0);
            tick();
        end
        operands_ok = 1'b1;
        #1 chk("t3_stall_release", 32'(id_stall), 32'd0);
        tick();
        br_valid = 1'b0;
        #1;
        chk("t3_valid", 32'(redir_valid), 32'd1);
        chk("t3_pc", redir_pc, 32'h0000_1044);
        tick();

        // 4: fetch backpressure while a second branch waits in ID
        redir_ready = 1'b0;
        set_br(1'b1, 1'b0, 32'h0000_2000, 16'h0001, 1'b1, 1'b1);
        tick();
        set_br(1'b1, 1'b0, 32'h0000_3000, 16'hFFFF, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t4_stall_hold", 32'(id_stall), 32'd1);
            chk("t4_valid_hold", 32'(redir_valid), 32'd1);
            chk("t4_pc_hold", redir_pc, 32'h0000_2008);
            tick();
        end
        redir_ready = 1'b1;
        #1 chk("t4_stall_ready", 32'(id_stall), 32'd1);
        tick();
        chk("t4_valid_gap", 32'(redir_valid), 32'd0);
        chk("t4_stall_consume", 32'(id_stall), 32'd0);
        tick();
        br_valid = 1'b0;
        #1;
        chk("t4_valid2", 32'(redir_valid), 32'd1);
        chk("t4_pc2", redir_pc, 32'h0000_3000);
        tick();

        // 5: target wraparound, then a register jump with the comparator low
        set_br(1'b1, 1'b0, 32'hFFFF_FFF8, 16'h0004, 1'b1, 1'b1);
        tick();
        br_valid = 1'b0;
        #1 chk("t5_wrap_pc", redir_pc, 32'h0000_000C);
        tick();
        reg_target = 32'h1234_5678;
        set_br(1'b1, 1'b1, 32'h0000_4000, 16'h0000, 1'b1, 1'b0);
        tick();
        br_valid = 1'b0;
        br_is_reg = 1'b0;
        #1;
        chk("t5_jr_valid", 32'(redir_valid), 32'd1);
        chk("t5_jr_pc", redir_pc, 32'h1234_5678);
        chk("t5_taken", stat_taken, STATS ? 32'd6 : 32'd0);
        tick();

        // 6a: reset in the middle of a held redirect
        redir_ready = 1'b0;
        set_br(1'b1, 1'b0, 32'h0000_5000, 16'h0002, 1'b1, 1'b1);
        tick();
        #1 chk("t6_hold_stall", 32'(id_stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_hold_valid", 32'(redir_valid), 32'd0);
        chk("t6_hold_stall_rst", 32'(id_stall), 32'd0);
        chk("t6_cnt_t", stat_taken, 32'd0);
        chk("t6_cnt_nt", stat_ntaken, 32'd0);
        tick();
        reset = 1'b0;
        br_valid = 1'b0;
        redir_ready = 1'b1;
        tick();
        chk("t6_hold_post", 32'(redir_valid), 32'd0);

        // 6b: reset in the middle of an operand wait
        set_br(1'b1, 1'b0, 32'h0000_6000, 16'h0003, 1'b0, 1'b1);
        tick();
        #1 chk("t6_wait_stall", 32'(id_stall), 32'd1);
        reset = 1'b1;
        #1 chk("t6_wait_stall_rst", 32'(id_stall), 32'd0);
        tick();
        br_valid = 1'b0;
        operands_ok = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_wait_post", 32'(redir_valid), 32'd0);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
